// File: rtl/serial_regfile_slave_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_regfile_slave_pkg : shared states, command codes and width helpers
// Rev 1.0
// ---------------------------------------------------------------------------
package serial_regfile_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_LOAD  = 3'd4,
        ST_SEND  = 3'd5
    } state_t;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    function automatic int calc_addr_w(input int nwr, input int nrd);
        int w;
        w = $clog2(nwr + nrd);
        return (w < 1) ? 1 : w;
    endfunction

    // Wide enough for both the data-bit and address-bit counts.
    function automatic int calc_cnt_w(input int reg_w, input int addr_w);
        int a;
        int b;
        a = $clog2(reg_w) + 1;
        b = $clog2(addr_w) + 1;
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_shift_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_shift_reg : LSB-first shift-in / parallel-load shift-out register
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_shift_reg
    import serial_regfile_slave_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // New bits enter at the MSB so the first bit received ends up in bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= din;
        end else if (shift) begin
            r_q <= {sin, r_q[WIDTH-1:1]};
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/serial_regfile_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_regfile_slave : framed 1-bit serial access to control/status regs
// Rev 1.0
// ---------------------------------------------------------------------------
module serial_regfile_slave
    import serial_regfile_slave_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter int NUM_WR    = 8,
    parameter int NUM_RD    = 2,
    parameter logic [NUM_WR*REG_WIDTH-1:0] RESET_VAL = '0,
    // A design without status inputs still gets a 1-bit rd_in port.
    localparam int RD_BITS  = (NUM_RD > 0) ? NUM_RD * REG_WIDTH : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        strobe,
    input  logic                        sdi,
    output logic                        sdo,
    output logic                        sdo_valid,
    output logic                        busy,
    output logic                        wr_done,
    output logic                        addr_err,
    input  logic [RD_BITS-1:0]          rd_in,
    output logic [NUM_WR*REG_WIDTH-1:0] wr_out
);

    localparam int ADDR_W  = calc_addr_w(NUM_WR, NUM_RD);
    localparam int CNT_W   = calc_cnt_w(REG_WIDTH, ADDR_W);
    localparam int AW_BITS = ADDR_W + REG_WIDTH;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_WIDTH - 1);

    state_t                 r_state;
    logic                   r_cmd;
    logic [CNT_W-1:0]       r_cnt;
    logic [REG_WIDTH-1:0]   r_regs [NUM_WR];
    logic                   r_sdo_valid;
    logic                   r_wr_done;
    logic                   r_addr_err;

    logic [AW_BITS-1:0]     w_aw_q;
    logic [AW_BITS-1:0]     w_aw_next;
    logic [ADDR_W-1:0]      w_rd_addr;
    logic [ADDR_W-1:0]      w_wr_addr;
    logic [REG_WIDTH-1:0]   w_wr_data;
    logic                   w_wr_in_range;
    logic                   w_data_last;
    logic                   w_abort;

    logic [REG_WIDTH-1:0]   w_rd_q;
    logic [REG_WIDTH-1:0]   w_rd_word;
    logic                   w_rd_hit;
    logic [REG_WIDTH-1:0]   w_snap;
    logic                   w_snap_err;
    logic                   w_rd_load;
    logic [REG_WIDTH-1:0]   w_rd_din;
    logic                   w_unused_bits;

    // Address and write data share one shifter; the address lands in the
    // low ADDR_W bits once the full frame has been shifted in.
    serial_shift_reg #(.WIDTH(AW_BITS)) u_aw_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (1'b0),
        .shift ((r_state == ST_ADDR) || (r_state == ST_WDATA)),
        .sin   (sdi),
        .din   ({AW_BITS{1'b0}}),
        .q     (w_aw_q)
    );

    serial_shift_reg #(.WIDTH(REG_WIDTH)) u_rd_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (w_rd_load),
        .shift (r_state == ST_SEND),
        .sin   (1'b0),
        .din   (w_rd_din),
        .q     (w_rd_q)
    );

    // The commit edge consumes the bit arriving on sdi in the same cycle.
    assign w_aw_next     = {sdi, w_aw_q[AW_BITS-1:1]};
    assign w_wr_addr     = w_aw_next[ADDR_W-1:0];
    assign w_wr_data     = w_aw_next[AW_BITS-1:ADDR_W];
    assign w_rd_addr     = w_aw_q[AW_BITS-1 -: ADDR_W];
    assign w_wr_in_range = 32'(w_wr_addr) < 32'(NUM_WR);
    assign w_data_last   = (r_state == ST_WDATA) && (r_cnt == DATA_LAST);
    assign w_abort       = strobe && (r_state != ST_IDLE) && !w_data_last;

    generate
        if (NUM_RD > 0) begin : g_rd
            always_comb begin
                w_rd_word = '0;
                w_rd_hit  = 1'b0;
                for (int i = 0; i < NUM_RD; i++) begin
                    if (32'(w_rd_addr) == 32'(NUM_WR + i)) begin
                        w_rd_word = rd_in[i*REG_WIDTH +: REG_WIDTH];
                        w_rd_hit  = 1'b1;
                    end
                end
            end
        end else begin : g_no_rd
            assign w_rd_word = '0;
            assign w_rd_hit  = 1'b0;
        end
    endgenerate

    always_comb begin
        w_snap     = w_rd_word;
        w_snap_err = !w_rd_hit;
        for (int i = 0; i < NUM_WR; i++) begin
            if (32'(w_rd_addr) == 32'(i)) begin
                w_snap     = r_regs[i];
                w_snap_err = 1'b0;
            end
        end
    end

    // A strobe during LOAD/SEND reloads zeros so sdo drops with sdo_valid.
    assign w_rd_load = (r_state == ST_LOAD) || (strobe && (r_state == ST_SEND));
    assign w_rd_din  = ((r_state == ST_LOAD) && !strobe) ? w_snap : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= CMD_READ;
            r_cnt       <= '0;
            r_sdo_valid <= 1'b0;
            r_wr_done   <= 1'b0;
            r_addr_err  <= 1'b0;
            for (int i = 0; i < NUM_WR; i++) begin
                r_regs[i] <= RESET_VAL[i*REG_WIDTH +: REG_WIDTH];
            end
        end else begin
            r_wr_done  <= 1'b0;
            r_addr_err <= 1'b0;
            if (w_abort) begin
                r_state     <= ST_CMD;
                r_cnt       <= '0;
                r_sdo_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (strobe) begin
                            r_state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        r_cmd   <= sdi;
                        r_cnt   <= '0;
                        r_state <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        if (r_cnt == ADDR_LAST) begin
                            r_cnt   <= '0;
                            r_state <= (r_cmd == CMD_WRITE) ? ST_WDATA : ST_LOAD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_WDATA: begin
                        if (w_data_last) begin
                            for (int i = 0; i < NUM_WR; i++) begin
                                if (32'(w_wr_addr) == 32'(i)) begin
                                    r_regs[i] <= w_wr_data;
                                end
                            end
                            r_wr_done  <= w_wr_in_range;
                            r_addr_err <= !w_wr_in_range;
                            r_cnt      <= '0;
                            r_state    <= strobe ? ST_CMD : ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        r_addr_err  <= w_snap_err;
                        r_sdo_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (r_cnt == DATA_LAST) begin
                            r_sdo_valid <= 1'b0;
                            r_cnt       <= '0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_WR; g++) begin : g_wr_out
            assign wr_out[g*REG_WIDTH +: REG_WIDTH] = r_regs[g];
        end
    endgenerate

    assign sdo       = w_rd_q[0];
    assign sdo_valid = r_sdo_valid;
    assign busy      = (r_state != ST_IDLE);
    assign wr_done   = r_wr_done;
    assign addr_err  = r_addr_err;

    assign w_unused_bits = ^{w_aw_q[0], w_rd_q[REG_WIDTH-1:1], rd_in};

endmodule
`default_nettype wire

// File: tb/tb_serial_regfile_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_regfile_slave : directed bench for default and narrow configs
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_serial_regfile_slave;

    localparam logic [255:0] RST_A = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005,
                                      32'h4444_0004, 32'h3333_0003, 32'h2222_0002,
                                      32'h1111_0001, 32'h3D1D_2400};
    localparam logic [23:0]  RST_B = 24'h11_5A_C3;

    logic         clk;
    logic         rst;
    logic         strobe_a, sdi_a, sdo_a, sdo_valid_a, busy_a, wr_done_a, addr_err_a;
    logic [63:0]  rd_in_a;
    logic [255:0] wr_out_a;
    logic         strobe_b, sdi_b, sdo_b, sdo_valid_b, busy_b, wr_done_b, addr_err_b;
    logic [0:0]   rd_in_b;
    logic [23:0]  wr_out_b;

    int           checks;
    int           failures;
    logic         exp_q[$];
    logic [255:0] m_a;
    logic [23:0]  m_b;
    logic [4:0]   o;

    serial_regfile_slave #(
        .REG_WIDTH(32), .NUM_WR(8), .NUM_RD(2), .RESET_VAL(RST_A)
    ) u_dut_a (
        .clk(clk), .rst(rst), .strobe(strobe_a), .sdi(sdi_a), .sdo(sdo_a),
        .sdo_valid(sdo_valid_a), .busy(busy_a), .wr_done(wr_done_a),
        .addr_err(addr_err_a), .rd_in(rd_in_a), .wr_out(wr_out_a)
    );

    serial_regfile_slave #(
        .REG_WIDTH(8), .NUM_WR(3), .NUM_RD(0), .RESET_VAL(RST_B)
    ) u_dut_b (
        .clk(clk), .rst(rst), .strobe(strobe_b), .sdi(sdi_b), .sdo(sdo_b),
        .sdo_valid(sdo_valid_b), .busy(busy_b), .wr_done(wr_done_b),
        .addr_err(addr_err_b), .rd_in(rd_in_b), .wr_out(wr_out_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {sdo, sdo_valid, busy, wr_done, addr_err}
    function automatic logic [4:0] outs(input bit dut);
        return dut ? {sdo_b, sdo_valid_b, busy_b, wr_done_b, addr_err_b}
                   : {sdo_a, sdo_valid_a, busy_a, wr_done_a, addr_err_a};
    endfunction

    function automatic logic [255:0] get_wr(input bit dut);
        return dut ? 256'(wr_out_b) : wr_out_a;
    endfunction

    function automatic logic [255:0] get_model(input bit dut);
        return dut ? 256'(m_b) : m_a;
    endfunction

    task automatic drive(input bit dut, input logic s, input logic d);
        if (dut) begin
            strobe_b = s;
            sdi_b    = d;
        end else begin
            strobe_a = s;
            sdi_a    = d;
        end
    endtask

    // Returns at the negedge where the last requested bit has been driven.
    task automatic frame(input bit dut, input bit strobed, input logic cmd,
                         input int addr, input logic [31:0] data, input int ndata);
        int aw;
        aw = dut ? 2 : 4;
        if (!strobed) begin
            @(negedge clk);
            drive(dut, 1'b1, 1'b0);
        end
        @(negedge clk);
        drive(dut, 1'b0, cmd);
        for (int i = 0; i < aw; i++) begin
            @(negedge clk);
            drive(dut, 1'b0, addr[i]);
        end
        for (int i = 0; i < ndata; i++) begin
            @(negedge clk);
            drive(dut, 1'b0, data[i]);
        end
    endtask

    task automatic do_write(input bit dut, input int addr, input logic [31:0] data,
                            input bit strobed, input bit chain);
        int w;
        int nwr;
        bit ok;
        logic [4:0] r;
        w   = dut ? 8 : 32;
        nwr = dut ? 3 : 8;
        ok  = addr < nwr;
        frame(dut, strobed, 1'b1, addr, data, w);
        r = outs(dut);
        check("wr_pre_commit", get_wr(dut), get_model(dut));
        check("wr_done_early", 256'(r[1]), 256'(0));
        @(negedge clk);
        drive(dut, chain, 1'b0);
        if (ok) begin
            if (dut) m_b[addr*8 +: 8] = data[7:0];
            else     m_a[addr*32 +: 32] = data;
        end
        r = outs(dut);
        check("wr_done", 256'(r[1]), 256'(ok));
        check("wr_addr_err", 256'(r[0]), 256'(!ok));
        check("wr_regs", get_wr(dut), get_model(dut));
        if (!chain) begin
            @(negedge clk);
            r = outs(dut);
            check("wr_pulse_end", 256'(r[1:0]), 256'(0));
        end
    endtask

    task automatic do_read(input bit dut, input int addr, input logic [31:0] exp,
                           input bit exp_err, input bit disturb);
        int w;
        int n;
        logic [4:0] r;
        w = dut ? 8 : 32;
        n = 0;
        frame(dut, 1'b0, 1'b0, addr, 32'h0, 0);
        for (int i = 0; i < w; i++) exp_q.push_back(exp[i]);
        @(negedge clk);
        drive(dut, 1'b0, 1'b0);
        @(negedge clk);
        r = outs(dut);
        while (!r[3] && n < 4) begin
            @(negedge clk);
            r = outs(dut);
            n++;
        end
        check("rd_valid_start", 256'(r[3]), 256'(1));
        check("rd_addr_err", 256'(r[0]), 256'(exp_err));
        for (int i = 0; i < w; i++) begin
            if (i > 0) begin
                @(negedge clk);
                r = outs(dut);
            end
            drive(dut, 1'b0, 1'($urandom_range(1)));
            if (disturb && i == 3) rd_in_a = ~rd_in_a;
            check("rd_bit", 256'({r[4], r[3]}), 256'({exp_q.pop_front(), 1'b1}));
        end
        @(negedge clk);
        drive(dut, 1'b0, 1'b0);
        r = outs(dut);
        check("rd_end", 256'(r[4:2]), 256'(0));
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        checks   = 0;
        failures = 0;
        strobe_a = 1'b0; sdi_a = 1'b0;
        strobe_b = 1'b0; sdi_b = 1'b0;
        rd_in_a  = {32'hDEAD_BEEF, 32'h0BAD_F00D};
        rd_in_b  = 1'b0;
        m_a      = RST_A;
        m_b      = RST_B;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        o = outs(1'b0);
        check("rst_outs_a", 256'(o), 256'(0));
        check("rst_wr_a", wr_out_a, RST_A);
        o = outs(1'b1);
        check("rst_outs_b", 256'(o), 256'(0));
        check("rst_wr_b", 256'(wr_out_b), 256'(RST_B));

        do_read(1'b0, 0, 32'h3D1D_2400, 1'b0, 1'b0);
        do_write(1'b0, 5, 32'hA5A5_0F0F, 1'b0, 1'b0);
        do_read(1'b0, 5, 32'hA5A5_0F0F, 1'b0, 1'b0);
        do_read(1'b0, 9, 32'hDEAD_BEEF, 1'b0, 1'b1);
        rd_in_a = {32'hDEAD_BEEF, 32'h0BAD_F00D};
        do_read(1'b0, 8, 32'h0BAD_F00D, 1'b0, 1'b0);

        do_write(1'b0, 9, 32'h1234_5678, 1'b0, 1'b0);
        do_write(1'b0, 15, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_read(1'b0, 15, 32'h0, 1'b1, 1'b0);

        // Strobe mid-data aborts the first frame; the restart commits.
        frame(1'b0, 1'b0, 1'b1, 2, 32'hFFFF_FFFF, 10);
        do_write(1'b0, 2, 32'h0000_0001, 1'b0, 1'b0);

        // Back-to-back: second strobe in the first idle cycle.
        do_write(1'b0, 1, 32'h1234_5678, 1'b0, 1'b1);
        do_write(1'b0, 3, 32'hCAFE_0003, 1'b1, 1'b0);
        do_read(1'b0, 1, 32'h1234_5678, 1'b0, 1'b0);

        // Reset during SEND.
        frame(1'b0, 1'b0, 1'b0, 5, 32'h0, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_a = RST_A;
        o = outs(1'b0);
        check("rst_send_outs", 256'(o), 256'(0));
        check("rst_send_wr", wr_out_a, RST_A);

        do_read(1'b1, 0, 32'hC3, 1'b0, 1'b0);
        do_write(1'b1, 2, 32'h96, 1'b0, 1'b0);
        do_read(1'b1, 2, 32'h96, 1'b0, 1'b0);
        do_write(1'b1, 3, 32'h55, 1'b0, 1'b0);
        do_read(1'b1, 1, 32'h5A, 1'b0, 1'b0);
        do_read(1'b1, 3, 32'h0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_regfile_slave.md
Name: serial_regfile_slave

Overview:
Parametrised serial-configured register bank, the next-generation configuration slave for the SerDes test chip. A 1-bit framed serial protocol (strobe, sdi, sdo) writes NUM_WR control registers and reads back any control register or NUM_RD read-only status inputs. Unlike the previous slave, it handles a generic width and depth, supports back-to-back frames and strobe re-sync, and flags out-of-range accesses. It sits between the pad-level serial interface and the analog/digital SerDes control and status nets.

Parameters:
REG_WIDTH, 32, bits per register (>=2)
NUM_WR, 8, number of writable control registers (>=1)
NUM_RD, 2, number of read-only status registers (>=0)
RESET_VAL, {NUM_WR*REG_WIDTH{1'b0}}, flat reset image; register i = bits [i*REG_WIDTH +: REG_WIDTH]
ADDR_W (localparam), clog2(NUM_WR+NUM_RD), address field width (min 1)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
strobe  in  1  frame start, one-cycle pulse
sdi  in  1  serial command/address/data in, LSB first
sdo  out  1  serial read data, registered, LSB first
sdo_valid  out  1  high while sdo carries a read bit
busy  out  1  frame in progress (state != IDLE)
wr_done  out  1  one-cycle pulse after a committed in-range write
addr_err  out  1  one-cycle pulse on an out-of-range address
rd_in  in  NUM_RD*REG_WIDTH  flat status inputs, addresses NUM_WR..NUM_WR+NUM_RD-1
wr_out  out  NUM_WR*REG_WIDTH  flat control registers, addresses 0..NUM_WR-1

Behaviour:
- Reset: wr_out=RESET_VAL; sdo, sdo_valid, busy, wr_done, addr_err = 0; state=IDLE; counters cleared. Reset mid-frame aborts the frame with no commit.
- Frame (strobe sampled at edge k): edge k+1 samples cmd bit (1=write, 0=read); edges k+2..k+1+ADDR_W sample the address LSB first.
- Write: edges k+2+ADDR_W..k+1+ADDR_W+REG_WIDTH sample data LSB first into a shift register. At the last data edge, the addressed register is updated (visible next cycle) and state returns to IDLE. wr_done is high for the following cycle. The register is never partially updated.
- Write out of range (addr>=NUM_WR, including read-only addresses): data is shifted and discarded; addr_err, not wr_done, pulses in the same cycle.
- Read: at edge k+2+ADDR_W (LOAD), a snapshot is taken of wr_out[addr] (addr<NUM_WR), of rd_in[addr-NUM_WR] (in range), or of zero plus an addr_err pulse (otherwise). Over the next REG_WIDTH cycles, sdo=snapshot[i] for i=0..REG_WIDTH-1 with sdo_valid=1. Then state=IDLE with sdo=0 and sdo_valid=0. sdi is ignored during SEND.
- States: IDLE -> CMD (strobe) -> ADDR -> WDATA -> IDLE, or ADDR -> LOAD -> SEND -> IDLE.
- strobe while busy: abort the current frame (no commit, sdo_valid drops) and restart at CMD on the next edge. Strobe on the final WDATA edge: the commit happens and the new frame starts.
- Back-to-back: strobe may be asserted in the first IDLE cycle after a frame.
- rd_in is sampled only at LOAD, so asynchronous status must be synchronised upstream.
- Counters are clog2(REG_WIDTH)+1 bits wide, so there is no wrap at REG_WIDTH=32.

Decomposition:
- Shared package/include holds the state encodings (IDLE, CMD, ADDR, WDATA, LOAD, SEND), the CMD_WRITE/CMD_READ constants and the ADDR_W calculation.
- One natural sub-module, serial_shift_reg: parametrised LSB-first shift-in/parallel-out and parallel-load/shift-out register, instantiated for both the address+write-data path and the read path.

Test Plan:
- After reset, read addr 0 with RESET_VAL[31:0]=32'h3D1D_2400 -> sdo streams 0x3D1D2400 LSB first over 32 cycles with sdo_valid=1 throughout; wr_out matches RESET_VAL.
- Write addr 5 = 32'hA5A5_0F0F -> wr_out[5] updates exactly one cycle after the last data bit; wr_done pulses once; the other registers are unchanged; a readback of addr 5 returns 32'hA5A5_0F0F.
- rd_in[1]=32'hDEAD_BEEF, read addr 9 -> sdo returns 0xDEADBEEF. Changing rd_in during SEND does not alter the streamed value.
- Write addr 9 and addr 15 -> no register changes; addr_err pulses; read addr 15 returns all zeros with addr_err pulsed.
- Strobe reasserted midway through write data to addr 2 -> wr_out[2] is unchanged; the restarted frame (write addr 2 = 32'h1) commits normally.
- Assert rst during SEND -> sdo and sdo_valid are 0 the next cycle and wr_out=RESET_VAL. A parameter sweep (REG_WIDTH=8, NUM_WR=3, NUM_RD=0) passes the same write/read checks.
